// File: rtl/e_mdu_ctrl_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: MD op codes and default latencies.
package e_mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYC = 5;
    localparam int MD_DIV_CYC  = 10;

    function automatic logic is_md_start(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_ctrl_md_arith.sv
// Combinational mult/div datapath: produces the 64-bit {hi,lo} result for the op in E
// and flags a divide by zero so the controller can suppress the commit.
module md_arith
    import e_mdu_ctrl_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        is_signed_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0
    // without relying on overflow behaviour of a signed divider.
    assign is_signed_div = (op == MD_DIV);
    assign a_mag   = (is_signed_div && a[31]) ? (32'd0 - a) : a;
    assign b_mag   = (is_signed_div && b[31]) ? (32'd0 - b) : b;
    assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign quot    = (is_signed_div && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
    assign rem     = (is_signed_div && a[31]) ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        hi   = 32'd0;
        lo   = 32'd0;
        div0 = 1'b0;
        case (op)
            MD_MULT:  {hi, lo} = prod_s;
            MD_MULTU: {hi, lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                hi   = rem;
                lo   = quot;
                div0 = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, sequences multi-cycle mult/div with a
// down-counter, and serves mfhi/mflo/mthi/mtlo.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   MD_IDLE | accepts start ops and mthi/mtlo; HI/LO hold committed values
//   MD_BUSY | result parked in shadow; counter runs down, commit at count 1
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYC,
    parameter int DIV_CYCLES  = MD_DIV_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic [31:0] E_MDOut,
    output logic        E_Start,
    output logic        E_Busy
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_op_e      op;
    md_state_e   state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0] hi, hi_n, lo, lo_n;
    logic [31:0] sh_hi, sh_hi_n, sh_lo, sh_lo_n;
    logic        commit_en, commit_en_n;
    logic [31:0] res_hi, res_lo;
    logic        res_div0;
    logic        is_div;

    assign op     = md_op_e'(E_MDOp);
    assign is_div = (op == MD_DIV) || (op == MD_DIVU);

    md_arith u_md_arith (
        .op   (op),
        .a    (E_A),
        .b    (E_B),
        .hi   (res_hi),
        .lo   (res_lo),
        .div0 (res_div0)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            sh_hi     <= 32'd0;
            sh_lo     <= 32'd0;
            commit_en <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hi        <= hi_n;
            lo        <= lo_n;
            sh_hi     <= sh_hi_n;
            sh_lo     <= sh_lo_n;
            commit_en <= commit_en_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hi_n        = hi;
        lo_n        = lo;
        sh_hi_n     = sh_hi;
        sh_lo_n     = sh_lo;
        commit_en_n = commit_en;
        case (state)
            MD_IDLE: begin
                if (is_md_start(op)) begin
                    sh_hi_n     = res_hi;
                    sh_lo_n     = res_lo;
                    commit_en_n = ~res_div0;
                    cnt_n       = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_n     = MD_BUSY;
                end else if (op == MD_MTHI) begin
                    hi_n = E_A;
                end else if (op == MD_MTLO) begin
                    lo_n = E_A;
                end
            end
            MD_BUSY: begin
                // Anything arriving in E while busy is ignored; only the countdown advances.
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = MD_IDLE;
                    if (commit_en) begin
                        hi_n = sh_hi;
                        lo_n = sh_lo;
                    end
                end
            end
            default: state_n = MD_IDLE;
        endcase
    end

    assign E_Start = is_md_start(op);
    assign E_Busy  = (state == MD_BUSY);
    assign E_MDOut = (op == MD_MFHI) ? hi :
                     (op == MD_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed self-checking bench for e_mdu_ctrl with hand-computed HI/LO and busy timing.
module tb_e_mdu_ctrl;
    import e_mdu_ctrl_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic [31:0] E_MDOut;
    logic        E_Start;
    logic        E_Busy;

    int errors = 0;
    int checks = 0;

    e_mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk     (clk),
        .reset   (reset),
        .E_MDOp  (E_MDOp),
        .E_A     (E_A),
        .E_B     (E_B),
        .E_MDOut (E_MDOut),
        .E_Start (E_Start),
        .E_Busy  (E_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_op();
        E_MDOp = MD_NONE;
        E_A    = 32'd0;
        E_B    = 32'd0;
    endtask

    task automatic rd(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        E_MDOp = MD_MFHI;
        #1 chk({tag, ".hi"}, E_MDOut, exp_hi);
        E_MDOp = MD_MFLO;
        #1 chk({tag, ".lo"}, E_MDOut, exp_lo);
        idle_op();
        #1;
    endtask

    // Issue a start op in the current cycle, then expect exactly n busy cycles.
    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int n);
        int busy_cnt;
        E_MDOp = op;
        E_A    = a;
        E_B    = b;
        #1 chk({tag, ".start"}, 32'(E_Start), 32'd1);
        step();
        idle_op();
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (E_Busy) busy_cnt++;
            step();
        end
        chk({tag, ".busy_cycles"}, busy_cnt, n);
        chk({tag, ".busy_done"}, 32'(E_Busy), 32'd0);
    endtask

    task automatic mt(input md_op_e op, input logic [31:0] v);
        E_MDOp = op;
        E_A    = v;
        step();
        idle_op();
    endtask

    initial begin
        int stall;
        int guard;

        reset = 1'b1;
        idle_op();
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst.busy", 32'(E_Busy), 32'd0);
        chk("rst.start", 32'(E_Start), 32'd0);
        rd("rst", 32'd0, 32'd0);

        // 1: signed mult
        run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, NM);
        rd("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        run_op("mult_nn", MD_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NM);
        rd("mult_nn", 32'd0, 32'd6);

        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NM);
        rd("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        // 2: divides
        run_op("divu", MD_DIVU, 32'd100, 32'd7, ND);
        rd("divu", 32'd2, 32'd14);

        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, ND);
        rd("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ND);
        rd("div_ovf", 32'd0, 32'h8000_0000);

        // 3: divide by zero leaves HI/LO alone
        mt(MD_MTHI, 32'h1234);
        mt(MD_MTLO, 32'h5678);
        rd("mt", 32'h1234, 32'h5678);
        run_op("div0", MD_DIV, 32'd55, 32'd0, ND);
        rd("div0", 32'h1234, 32'h5678);
        run_op("divu0", MD_DIVU, 32'd55, 32'd0, ND);
        rd("divu0", 32'h1234, 32'h5678);

        // 4: mflo waiting in D stalls while E_Start|E_Busy
        E_MDOp = MD_MULT;
        E_A    = 32'h10;
        E_B    = 32'h10;
        #1;
        stall = 0;
        guard = 0;
        while ((E_Start || E_Busy) && guard < 50) begin
            stall++;
            guard++;
            step();
            idle_op();
            #1;
        end
        chk("haz.stall", stall, NM + 1);
        E_MDOp = MD_MFLO;
        #1 chk("haz.mflo", E_MDOut, 32'h100);
        idle_op();
        step();

        // back-to-back multu: second only issues after first commits
        E_MDOp = MD_MULTU;
        E_A    = 32'd2;
        E_B    = 32'd3;
        #1;
        stall = 0;
        guard = 0;
        while ((E_Start || E_Busy) && guard < 50) begin
            stall++;
            guard++;
            step();
            idle_op();
            #1;
        end
        chk("b2b.stall", stall, NM + 1);
        rd("b2b.first", 32'd0, 32'd6);
        run_op("b2b.second", MD_MULTU, 32'd5, 32'd7, NM);
        rd("b2b.second", 32'd0, 32'd35);

        // 6: defensive behaviour while busy
        run_op("pre", MD_MULTU, 32'd3, 32'd4, NM);
        E_MDOp = MD_MULT;
        E_A    = 32'd6;
        E_B    = 32'd7;
        step();
        E_MDOp = MD_DIVU;
        E_A    = 32'd100;
        E_B    = 32'd7;
        #1 chk("def.busy1", 32'(E_Busy), 32'd1);
        step();
        E_MDOp = MD_MTHI;
        E_A    = 32'hAAAA_AAAA;
        step();
        E_MDOp = MD_MFLO;
        #1 chk("def.mflo_old", E_MDOut, 32'd12);
        E_MDOp = MD_MFHI;
        #1 chk("def.mfhi_old", E_MDOut, 32'd0);
        step();
        idle_op();
        step();
        chk("def.busy_last", 32'(E_Busy), 32'd1);
        step();
        chk("def.busy_end", 32'(E_Busy), 32'd0);
        rd("def", 32'd0, 32'd42);

        mt(MD_MTHI, 32'hDEAD_BEEF);
        E_MDOp = MD_MFHI;
        #1 chk("mthi_mfhi", E_MDOut, 32'hDEAD_BEEF);
        E_MDOp = MD_MTLO;
        #1 chk("mtlo.out_zero", E_MDOut, 32'd0);
        idle_op();
        step();

        // 5: reset in the middle of a divide
        E_MDOp = MD_DIVU;
        E_A    = 32'd100;
        E_B    = 32'd7;
        step();
        idle_op();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid.busy", 32'(E_Busy), 32'd0);
        rd("rstmid", 32'd0, 32'd0);
        for (int i = 0; i < ND + 2; i++) step();
        chk("rstmid.busy_late", 32'(E_Busy), 32'd0);
        rd("rstmid.late", 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
